tl45_register_read: RTL
=======================

# tl45_register_read

Operand-fetch stage of the TL45 pipeline, placed between decode and `tl45_alu`. It reads a 16×32 register file and resolves operands by forwarding from the ALU, memory stage and writeback. It inserts bubbles on unresolved memory-stage (load) hazards and drives the ALU input buffer under the shared stall/flush protocol.

## Interface
Parameters:
- `NREGS`, 16: register count; index width is 4; r0 reads as zero.

Ports:
- `i_clk`  in  1  clock; one clock domain.
- `i_reset`  in  1  reset; synchronous, active-high.
- `i_pipe_stall`  in  1  stall from downstream (ALU `o_pipe_stall`).
- `o_pipe_stall`  out  1  stall to decode.
- `i_pipe_flush`  in  1  flush from downstream (ALU `o_pipe_flush`).
- `o_pipe_flush`  out  1  flush to decode.
- `i_opcode`  in  5  decoded opcode; 0 is NOP.
- `i_dr`, `i_sr1`, `i_sr2`  in  4 each  destination and source register indices.
- `i_imm_en`  in  1  when high, sr2 operand is `i_imm`.
- `i_imm`  in  32  sign-extended immediate.
- `i_jmp_cond`  in  4  branch condition, passed through.
- `i_target_offset`, `i_pc`  in  32 each  passed through.
- `i_of1_reg`, `i_of1_val`  in  4 / 32  ALU forward; reg 0 means none.
- `i_of2_reg`, `i_of2_val`, `i_of2_pending`  in  4 / 32 / 1  memory-stage forward; `pending` means the value is not yet available.
- `i_wb_reg`, `i_wb_val`  in  4 / 32  register-file write; reg 0 means no write.
- `o_opcode`, `o_dr`, `o_jmp_cond`  out  5 / 4 / 4  registered, to ALU.
- `o_sr1_val`, `o_sr2_val`, `o_target_offset`, `o_pc`  out  32 each  registered, to ALU.

## Operation
- Register file:
  - Write `i_wb_val` to `i_wb_reg` at the clock edge when `i_wb_reg != 0`.
  - r0 always reads 0.
  - Reset clears all entries to 0.
- Operand resolution, per source, in priority order:
  - src == 0 → 0.
  - src == `i_of1_reg` → `i_of1_val`.
  - src == `i_of2_reg` and not pending → `i_of2_val`.
  - src == `i_wb_reg` → `i_wb_val` (same-cycle bypass).
  - otherwise → register-file value.
- sr2 select: when `i_imm_en`, sr2 = `i_imm` and sr2 takes part in neither forwarding nor the hazard check.
- Hazard: `hz` = a used, nonzero source equals `i_of2_reg`, `i_of2_pending` is high, and the source does not also match `i_of1_reg`.
- Handshakes:
  - `o_pipe_stall = i_pipe_stall || (hz && !i_pipe_flush)`.
  - `o_pipe_flush = i_pipe_flush`.
- Buffer update at each edge, first matching case wins:
  1. `i_reset` or `i_pipe_flush`: all outputs ← 0.
  2. `i_pipe_stall`: hold all outputs.
  3. `hz`: outputs ← 0 (bubble); decode holds its bundle.
  4. otherwise: load the resolved operands and pass-through fields.
- A NOP bundle (`i_opcode == 0`) is loaded as-is, with operands resolved normally. No special case.

## Timing
- Latency: one cycle, decode bundle to ALU inputs.
- The cycle after `o_pipe_flush` is asserted, every output is 0. This is the contract the ALU relies on.
- The cycle after `o_pipe_stall` due to `i_pipe_stall`, every output equals its previous value.
- Hazard stall:
  - A bubble is emitted on every cycle `hz` holds.
  - The held instruction issues on the first cycle `i_of2_pending` drops, using `i_of2_val`.
- Flush has priority over stall and hazard: a flush during a hazard clears the buffer, and `o_pipe_stall` follows `i_pipe_stall` only.
- Writeback during stall: the register file updates regardless of stall. The held buffer does not re-resolve, because the downstream forward covers the gap.
- Reset mid-operation: outputs and register file read 0 on the next cycle. Reset overrides stall.
- Reset value of all outputs is 0. `o_pipe_stall` and `o_pipe_flush` are combinational from inputs.

## Structure
- Shared package `tl45_pkg`:
  - opcode constants (NOP=0, ADD=1, SUB=2, OR=6, XOR=7, AND=8, NOT=9, BR=0xC, CALL=0xD, RET=0xE);
  - register index width (4);
  - the "no register" value 0.
- Sub-module `tl45_regfile`: 16×32, two asynchronous read ports, one synchronous write port, synchronous reset, r0 hardwired to 0.
- Forward mux and hazard compare stay in `tl45_register_read`.

## Test plan
- Write r3=0x1234 via wb, then ADD r1,r3,r3 two cycles later → `o_sr1_val=o_sr2_val=0x1234`, `o_dr=1`, `o_opcode=1`, one cycle later.
- `i_of1_reg=5`, `i_of1_val=0xAA`, and `i_of2_reg=5`, `i_of2_val=0xBB`, with sr1=5 → `o_sr1_val=0xAA`. Then r0 as source → 0 even when `i_of1_reg=0`, `i_wb_reg=0`.
- `i_of2_reg=4` pending for 3 cycles, sr2=4 → `o_pipe_stall` high 3 cycles, 3 zero bubbles out, then issue with `i_of2_val`. Repeat with `i_imm_en=1` → no stall, `o_sr2_val=i_imm`.
- `i_pipe_stall` high 2 cycles mid-stream → outputs frozen, decode stalled, and a wb to the same register does not change held outputs.
- `i_pipe_flush` high while `hz` and `i_pipe_stall` are both high → next-cycle outputs all 0, `o_pipe_flush=1`, `o_pipe_stall=1` only via `i_pipe_stall`.
- Assert `i_reset` after loading r1..r15 → next cycle outputs 0, and all register reads return 0.

Source files
------------

// File: rtl/tl45_pkg.sv
// Shared TL45 pipeline definitions: opcode encodings, register index width
// and the forwarding-match helper used by the operand-fetch stage.
package tl45_pkg;

    localparam int REG_W  = 4;
    localparam int DATA_W = 32;
    localparam int OPC_W  = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_NONE = '0;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 5'h00,
        OP_ADD  = 5'h01,
        OP_SUB  = 5'h02,
        OP_OR   = 5'h06,
        OP_XOR  = 5'h07,
        OP_AND  = 5'h08,
        OP_NOT  = 5'h09,
        OP_BR   = 5'h0C,
        OP_CALL = 5'h0D,
        OP_RET  = 5'h0E
    } opcode_e;

    // A forward source only matches a real register; index 0 never forwards.
    function automatic logic fwd_hit(input reg_idx_t src, input reg_idx_t fwd);
        return (src != REG_NONE) && (src == fwd);
    endfunction

endpackage

// File: rtl/tl45_register_read_if.sv
// Decode-to-ALU bundle plus forwarding/writeback buses and the stall/flush
// handshake seen by the operand-fetch stage.
interface tl45_register_read_if;
    import tl45_pkg::*;

    logic                i_pipe_stall;
    logic                o_pipe_stall;
    logic                i_pipe_flush;
    logic                o_pipe_flush;

    logic [OPC_W-1:0]    i_opcode;
    reg_idx_t            i_dr;
    reg_idx_t            i_sr1;
    reg_idx_t            i_sr2;
    logic                i_imm_en;
    logic [DATA_W-1:0]   i_imm;
    logic [3:0]          i_jmp_cond;
    logic [DATA_W-1:0]   i_target_offset;
    logic [DATA_W-1:0]   i_pc;

    reg_idx_t            i_of1_reg;
    logic [DATA_W-1:0]   i_of1_val;
    reg_idx_t            i_of2_reg;
    logic [DATA_W-1:0]   i_of2_val;
    logic                i_of2_pending;
    reg_idx_t            i_wb_reg;
    logic [DATA_W-1:0]   i_wb_val;

    logic [OPC_W-1:0]    o_opcode;
    reg_idx_t            o_dr;
    logic [3:0]          o_jmp_cond;
    logic [DATA_W-1:0]   o_sr1_val;
    logic [DATA_W-1:0]   o_sr2_val;
    logic [DATA_W-1:0]   o_target_offset;
    logic [DATA_W-1:0]   o_pc;

    modport slave (
        input  i_pipe_stall, i_pipe_flush,
        input  i_opcode, i_dr, i_sr1, i_sr2, i_imm_en, i_imm,
        input  i_jmp_cond, i_target_offset, i_pc,
        input  i_of1_reg, i_of1_val, i_of2_reg, i_of2_val, i_of2_pending,
        input  i_wb_reg, i_wb_val,
        output o_pipe_stall, o_pipe_flush,
        output o_opcode, o_dr, o_jmp_cond, o_sr1_val, o_sr2_val,
        output o_target_offset, o_pc
    );

    modport master (
        output i_pipe_stall, i_pipe_flush,
        output i_opcode, i_dr, i_sr1, i_sr2, i_imm_en, i_imm,
        output i_jmp_cond, i_target_offset, i_pc,
        output i_of1_reg, i_of1_val, i_of2_reg, i_of2_val, i_of2_pending,
        output i_wb_reg, i_wb_val,
        input  o_pipe_stall, o_pipe_flush,
        input  o_opcode, o_dr, o_jmp_cond, o_sr1_val, o_sr2_val,
        input  o_target_offset, o_pc
    );

endinterface

// File: rtl/tl45_regfile.sv
// TL45 register file: two asynchronous read ports, one synchronous write
// port, synchronous clear; r0 is hardwired to zero.
module tl45_regfile
    import tl45_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  reg_idx_t          i_rd_a,
    input  reg_idx_t          i_rd_b,
    output logic [DATA_W-1:0] o_rd_a,
    output logic [DATA_W-1:0] o_rd_b,
    input  reg_idx_t          i_wr_reg,
    input  logic [DATA_W-1:0] i_wr_val
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (i_wr_reg != REG_NONE) begin
            regs[i_wr_reg] <= i_wr_val;
        end
    end

    assign o_rd_a = (i_rd_a == REG_NONE) ? '0 : regs[i_rd_a];
    assign o_rd_b = (i_rd_b == REG_NONE) ? '0 : regs[i_rd_b];

endmodule

// File: rtl/tl45_register_read.sv
// TL45 operand-fetch stage: reads the register file, resolves operands via
// ALU/memory/writeback forwarding, and bubbles on pending memory-stage loads.
module tl45_register_read
    import tl45_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    tl45_register_read_if.slave  bus
);

    logic [DATA_W-1:0] rf_a, rf_b;
    logic [DATA_W-1:0] sr1_res, sr2_res;
    logic              hz_sr1, hz_sr2, hz;

    logic [OPC_W-1:0]  opcode_p1;
    reg_idx_t          dr_p1;
    logic [3:0]        jmp_cond_p1;
    logic [DATA_W-1:0] sr1_val_p1, sr2_val_p1, target_offset_p1, pc_p1;

    tl45_regfile #(.NREGS(NREGS)) u_regfile (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_rd_a   (bus.i_sr1),
        .i_rd_b   (bus.i_sr2),
        .o_rd_a   (rf_a),
        .o_rd_b   (rf_b),
        .i_wr_reg (bus.i_wb_reg),
        .i_wr_val (bus.i_wb_val)
    );

    function automatic logic [DATA_W-1:0] resolve(
        input reg_idx_t          src,
        input logic [DATA_W-1:0] rf_val,
        input reg_idx_t          of1_reg,
        input logic [DATA_W-1:0] of1_val,
        input reg_idx_t          of2_reg,
        input logic [DATA_W-1:0] of2_val,
        input logic              of2_pending,
        input reg_idx_t          wb_reg,
        input logic [DATA_W-1:0] wb_val
    );
        if (src == REG_NONE)                        return '0;
        else if (fwd_hit(src, of1_reg))             return of1_val;
        else if (fwd_hit(src, of2_reg) && !of2_pending) return of2_val;
        else if (fwd_hit(src, wb_reg))              return wb_val;
        else                                        return rf_val;
    endfunction

    always_comb begin
        sr1_res = resolve(bus.i_sr1, rf_a, bus.i_of1_reg, bus.i_of1_val,
                          bus.i_of2_reg, bus.i_of2_val, bus.i_of2_pending,
                          bus.i_wb_reg, bus.i_wb_val);
        sr2_res = bus.i_imm_en ? bus.i_imm :
                  resolve(bus.i_sr2, rf_b, bus.i_of1_reg, bus.i_of1_val,
                          bus.i_of2_reg, bus.i_of2_val, bus.i_of2_pending,
                          bus.i_wb_reg, bus.i_wb_val);
    end

    // A newer ALU result for the same register shadows the pending load.
    assign hz_sr1 = fwd_hit(bus.i_sr1, bus.i_of2_reg) && bus.i_of2_pending &&
                    !fwd_hit(bus.i_sr1, bus.i_of1_reg);
    assign hz_sr2 = !bus.i_imm_en &&
                    fwd_hit(bus.i_sr2, bus.i_of2_reg) && bus.i_of2_pending &&
                    !fwd_hit(bus.i_sr2, bus.i_of1_reg);
    assign hz     = hz_sr1 || hz_sr2;

    assign bus.o_pipe_stall = bus.i_pipe_stall || (hz && !bus.i_pipe_flush);
    assign bus.o_pipe_flush = bus.i_pipe_flush;

    // Stage boundary: decode bundle -> ALU input buffer.
    always_ff @(posedge i_clk) begin
        if (i_reset || bus.i_pipe_flush || (hz && !bus.i_pipe_stall)) begin
            opcode_p1        <= '0;
            dr_p1            <= '0;
            jmp_cond_p1      <= '0;
            sr1_val_p1       <= '0;
            sr2_val_p1       <= '0;
            target_offset_p1 <= '0;
            pc_p1            <= '0;
        end else if (!bus.i_pipe_stall) begin
            opcode_p1        <= bus.i_opcode;
            dr_p1            <= bus.i_dr;
            jmp_cond_p1      <= bus.i_jmp_cond;
            sr1_val_p1       <= sr1_res;
            sr2_val_p1       <= sr2_res;
            target_offset_p1 <= bus.i_target_offset;
            pc_p1            <= bus.i_pc;
        end
    end

    assign bus.o_opcode        = opcode_p1;
    assign bus.o_dr            = dr_p1;
    assign bus.o_jmp_cond      = jmp_cond_p1;
    assign bus.o_sr1_val       = sr1_val_p1;
    assign bus.o_sr2_val       = sr2_val_p1;
    assign bus.o_target_offset = target_offset_p1;
    assign bus.o_pc            = pc_p1;

endmodule
